// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage of the 8-bit nRISC core.
// Presents pc to instruction memory, latches the returned word toward decode with a
// valid/ready handshake, computes the next PC (sequential, redirect or hold) and raises
// encerra once decode accepts the halt instruction.
// Optional feature: define INSTR_FETCH_PERF_EN to add the saturating fetch_count output.
module instr_fetch #(
  parameter int unsigned          ADDR_W     = 8,
  parameter int unsigned          DATA_W     = 8,
  parameter logic [DATA_W-1:0]    HALT_INSTR = DATA_W'(8'hFF)
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [DATA_W-1:0] imem_data,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  input  logic              id_ready,
  output logic [ADDR_W-1:0] next_pc,
  output logic              encerra,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
`ifdef INSTR_FETCH_PERF_EN
  output logic [15:0]       fetch_count,
`endif
  output logic              instr_valid
);

  typedef enum logic [1:0] {StFetch, StHaltPend, StHalted} state_e;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0] instr_pc_q, instr_pc_d;
  logic              valid_q, valid_d;
  logic              encerra_q, encerra_d;
  logic [ADDR_W-1:0] next_pc_c;
  logic              accept, load;

  assign imem_addr   = pc;
  assign instr       = instr_q;
  assign instr_pc    = instr_pc_q;
  assign instr_valid = valid_q;
  assign encerra     = encerra_q;
  // The PC register samples next_pc while held in reset, so force it to zero.
  assign next_pc     = reset_n ? next_pc_c : '0;

  // Next-state, next-PC and fetch-register update; branch beats halt beats load beats hold.
  always_comb begin
    state_d    = state_q;
    instr_d    = instr_q;
    instr_pc_d = instr_pc_q;
    valid_d    = valid_q;
    encerra_d  = encerra_q;
    next_pc_c  = pc;
    accept     = valid_q & id_ready;
    load       = (state_q == StFetch) & (~valid_q | id_ready) & ~branch_taken;
    case (state_q)
      StFetch: begin
        if (branch_taken) begin
          next_pc_c = branch_target;
          valid_d   = 1'b0;
        end else if (load) begin
          instr_d    = imem_data;
          instr_pc_d = pc;
          valid_d    = 1'b1;
          next_pc_c  = pc + ADDR_W'(1);
          if (imem_data == HALT_INSTR) state_d = StHaltPend;
        end else if (accept) begin
          valid_d = 1'b0;
        end
      end
      StHaltPend: begin
        // A redirect squashes the pending halt along with its instruction.
        if (branch_taken) begin
          next_pc_c = branch_target;
          valid_d   = 1'b0;
          state_d   = StFetch;
        end else if (accept) begin
          valid_d   = 1'b0;
          encerra_d = 1'b1;
          state_d   = StHalted;
        end
      end
      StHalted: begin
        valid_d   = 1'b0;
        encerra_d = 1'b1;
      end
      default: state_d = StFetch;
    endcase
  end

  // State and fetch registers; asynchronous reset clears everything.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= StFetch;
      instr_q    <= '0;
      instr_pc_q <= '0;
      valid_q    <= 1'b0;
      encerra_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      instr_q    <= instr_d;
      instr_pc_q <= instr_pc_d;
      valid_q    <= valid_d;
      encerra_q  <= encerra_d;
    end
  end

`ifdef INSTR_FETCH_PERF_EN
  logic [15:0] fetch_count_q;

  assign fetch_count = fetch_count_q;

  // Counts instructions handed to decode, saturating; survives branch and halt.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      fetch_count_q <= '0;
    end else if (accept && (fetch_count_q != 16'hFFFF)) begin
      fetch_count_q <= fetch_count_q + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: self-checking bench for instr_fetch with a behavioural model of the
// fetch stage plus the PC register it feeds.
module tb_instr_fetch;

  localparam logic [7:0] HALT = 8'hFF;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic [7:0] pc = '0;
  logic [7:0] imem_addr, imem_data, branch_target, next_pc, instr, instr_pc;
  logic       branch_taken = 1'b0, id_ready = 1'b0, encerra, instr_valid;
`ifdef INSTR_FETCH_PERF_EN
  logic [15:0] fetch_count;
`endif

  logic [7:0] imem [256];
  assign imem_data = imem[imem_addr];

  always #5 clock = ~clock;

  instr_fetch dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .pc           (pc),
    .imem_addr    (imem_addr),
    .imem_data    (imem_data),
    .branch_taken (branch_taken),
    .branch_target(branch_target),
    .id_ready     (id_ready),
    .next_pc      (next_pc),
    .encerra      (encerra),
    .instr        (instr),
    .instr_pc     (instr_pc),
`ifdef INSTR_FETCH_PERF_EN
    .fetch_count  (fetch_count),
`endif
    .instr_valid  (instr_valid)
  );

  int errors = 0;
  int checks = 0;

  // Model: the PC register, the live instruction slot, and a halted flag.
  // A halt is pending exactly when the live instruction is the halt word.
  logic [7:0] m_pc, m_next, m_instr, m_ipc;
  logic       m_valid, m_halted;
  int         m_count;

  // Hold reset across one rising edge; returns at posedge+1 with reset released.
  task automatic do_reset();
    reset_n = 1'b0;
    branch_taken = 1'b0; id_ready = 1'b0; branch_target = '0;
    m_pc = '0; m_next = '0; m_instr = '0; m_ipc = '0;
    m_valid = 1'b0; m_halted = 1'b0; m_count = 0;
    pc = m_pc;
    @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // Apply inputs for the coming edge and predict next_pc.
  task automatic drive(input logic b, input logic [7:0] t, input logic r);
    logic pend;
    branch_taken = b; branch_target = t; id_ready = r; pc = m_pc;
    pend = m_valid && (m_instr == HALT);
    if (m_halted)                      m_next = m_pc;
    else if (b)                        m_next = t;
    else if (!pend && (!m_valid || r)) m_next = 8'(m_pc + 8'd1);
    else                               m_next = m_pc;
    #1;
  endtask

  // Advance one clock edge and update the model.
  task automatic tick();
    logic pend, acc;
    @(posedge clock);
    pend = m_valid && (m_instr == HALT);
    acc  = m_valid && id_ready;
    if (!m_halted) begin
      if (branch_taken) m_valid = 1'b0;
      else if (pend) begin
        if (acc) begin m_valid = 1'b0; m_halted = 1'b1; end
      end else if (!m_valid || id_ready) begin
        m_instr = imem[m_pc]; m_ipc = m_pc; m_valid = 1'b1;
      end
    end
    if (acc && m_count < 65535) m_count++;
    m_pc = m_next;
    #1;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; pc = 8'h33;
    #2;
    checks++; if (next_pc !== 8'h00) begin errors++; $display("FAIL reset next_pc: got %h want 00", next_pc); end
    checks++; if (imem_addr !== 8'h33) begin errors++; $display("FAIL reset imem_addr: got %h want 33", imem_addr); end
    checks++; if ({instr, instr_pc, instr_valid, encerra} !== 18'h0) begin
      errors++; $display("FAIL reset regs: got instr=%h pc=%h v=%b e=%b want zeros", instr, instr_pc, instr_valid, encerra);
    end
`ifdef INSTR_FETCH_PERF_EN
    checks++; if (fetch_count !== 16'h0) begin errors++; $display("FAIL reset fetch_count: got %h want 0", fetch_count); end
`endif
    do_reset();
  endtask

  task automatic test_sequential();
    logic [7:0] words [3];
    words[0] = 8'h10; words[1] = 8'h11; words[2] = 8'h12;
    for (int i = 0; i < 3; i++) imem[i] = words[i];
    do_reset();
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b1);
      checks++; if (next_pc !== 8'(i + 1)) begin errors++; $display("FAIL seq next_pc: got %h want %h", next_pc, 8'(i + 1)); end
      tick();
      checks++; if (instr !== words[i] || instr_pc !== 8'(i) || instr_valid !== 1'b1) begin
        errors++; $display("FAIL seq instr: got %h@%h v=%b want %h@%h v=1", instr, instr_pc, instr_valid, words[i], 8'(i));
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    repeat (2) begin drive(1'b0, 8'h00, 1'b1); tick(); end
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 8'h00, 1'b0);
      checks++; if (next_pc !== 8'h02) begin errors++; $display("FAIL stall next_pc: got %h want 02", next_pc); end
      tick();
      checks++; if (instr !== 8'h11 || instr_pc !== 8'h01 || instr_valid !== 1'b1) begin
        errors++; $display("FAIL stall hold: got %h@%h v=%b want 11@01 v=1", instr, instr_pc, instr_valid);
      end
    end
    drive(1'b0, 8'h00, 1'b1);
    checks++; if (next_pc !== 8'h03) begin errors++; $display("FAIL stall resume next_pc: got %h want 03", next_pc); end
    tick();
    checks++; if (instr !== 8'h12 || instr_pc !== 8'h02) begin errors++; $display("FAIL stall resume: got %h@%h want 12@02", instr, instr_pc); end
  endtask

  task automatic test_branch();
    imem[8'h40] = 8'h5A;
    drive(1'b1, 8'h40, 1'b1);
    checks++; if (next_pc !== 8'h40) begin errors++; $display("FAIL branch next_pc: got %h want 40", next_pc); end
    tick();
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL branch bubble: got v=%b want 0", instr_valid); end
    drive(1'b0, 8'h00, 1'b1);
    checks++; if (next_pc !== 8'h41) begin errors++; $display("FAIL branch next_pc2: got %h want 41", next_pc); end
    tick();
    checks++; if (instr_pc !== 8'h40 || instr !== 8'h5A || instr_valid !== 1'b1) begin
      errors++; $display("FAIL branch target: got %h@%h v=%b want 5a@40 v=1", instr, instr_pc, instr_valid);
    end
  endtask

  task automatic test_wrap();
    imem[8'hFF] = 8'h3C; imem[8'h00] = 8'h10;
    drive(1'b1, 8'hFF, 1'b1); tick();
    drive(1'b0, 8'h00, 1'b1);
    checks++; if (next_pc !== 8'h00) begin errors++; $display("FAIL wrap next_pc: got %h want 00", next_pc); end
    tick();
    checks++; if (instr_pc !== 8'hFF) begin errors++; $display("FAIL wrap instr_pc: got %h want ff", instr_pc); end
    drive(1'b0, 8'h00, 1'b1); tick();
    checks++; if (instr_pc !== 8'h00 || instr !== 8'h10) begin errors++; $display("FAIL wrap next: got %h@%h want 10@00", instr, instr_pc); end
  endtask

  task automatic test_halt();
    for (int i = 0; i < 5; i++) imem[i] = 8'(i + 1);
    imem[5] = HALT;
    do_reset();
    repeat (6) begin drive(1'b0, 8'h00, 1'b1); tick(); end
    checks++; if (instr !== HALT || instr_pc !== 8'h05) begin errors++; $display("FAIL halt fetch: got %h@%h want ff@05", instr, instr_pc); end
    drive(1'b0, 8'h00, 1'b0);
    checks++; if (next_pc !== 8'h06) begin errors++; $display("FAIL halt pend next_pc: got %h want 06", next_pc); end
    tick();
    checks++; if (encerra !== 1'b0 || instr_valid !== 1'b1) begin errors++; $display("FAIL halt pend: got e=%b v=%b want e=0 v=1", encerra, instr_valid); end
    drive(1'b0, 8'h00, 1'b1);
    checks++; if (next_pc !== 8'h06) begin errors++; $display("FAIL halt accept next_pc: got %h want 06", next_pc); end
    tick();
    checks++; if (encerra !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL halt accept: got e=%b v=%b want e=1 v=0", encerra, instr_valid); end
    for (int i = 0; i < 10; i++) begin
      drive(1'(i % 2), 8'($urandom), 1'($urandom));
      checks++; if (next_pc !== 8'h06) begin errors++; $display("FAIL halted next_pc: got %h want 06", next_pc); end
      tick();
      checks++; if (encerra !== 1'b1 || instr_valid !== 1'b0) begin errors++; $display("FAIL halted: got e=%b v=%b want e=1 v=0", encerra, instr_valid); end
    end
  endtask

  task automatic test_reset_in_halted();
    #3 reset_n = 1'b0;
    #1;
    checks++; if ({instr, instr_pc, instr_valid, encerra} !== 18'h0 || next_pc !== 8'h00) begin
      errors++; $display("FAIL async reset: got instr=%h pc=%h v=%b e=%b np=%h want zeros", instr, instr_pc, instr_valid, encerra, next_pc);
    end
    do_reset();
  endtask

  task automatic test_halt_branch();
    imem[0] = HALT; imem[8'h20] = 8'h21;
    do_reset();
    drive(1'b0, 8'h00, 1'b1); tick();
    drive(1'b1, 8'h20, 1'b1);
    checks++; if (next_pc !== 8'h20) begin errors++; $display("FAIL halt squash next_pc: got %h want 20", next_pc); end
    tick();
    checks++; if (encerra !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL halt squash: got e=%b v=%b want e=0 v=0", encerra, instr_valid); end
    drive(1'b0, 8'h00, 1'b1);
    checks++; if (next_pc !== 8'h21) begin errors++; $display("FAIL halt squash resume next_pc: got %h want 21", next_pc); end
    tick();
    checks++; if (instr_pc !== 8'h20 || instr !== 8'h21 || encerra !== 1'b0) begin
      errors++; $display("FAIL halt squash resume: got %h@%h e=%b want 21@20 e=0", instr, instr_pc, encerra);
    end
  endtask

  task automatic test_random();
    int halted_cycles = 0;
    for (int i = 0; i < 256; i++) imem[i] = ($urandom_range(0, 15) == 0) ? HALT : 8'($urandom_range(0, 254));
    do_reset();
    for (int n = 0; n < 400; n++) begin
      drive(1'($urandom_range(0, 7) == 0), 8'($urandom), 1'($urandom_range(0, 3) != 0));
      checks++; if (next_pc !== m_next) begin errors++; $display("FAIL rand next_pc: got %h want %h", next_pc, m_next); end
      checks++; if (imem_addr !== m_pc) begin errors++; $display("FAIL rand imem_addr: got %h want %h", imem_addr, m_pc); end
      tick();
      checks++; if (instr !== m_instr || instr_pc !== m_ipc) begin
        errors++; $display("FAIL rand instr: got %h@%h want %h@%h", instr, instr_pc, m_instr, m_ipc);
      end
      checks++; if (instr_valid !== m_valid || encerra !== m_halted) begin
        errors++; $display("FAIL rand flags: got v=%b e=%b want v=%b e=%b", instr_valid, encerra, m_valid, m_halted);
      end
`ifdef INSTR_FETCH_PERF_EN
      checks++; if (fetch_count !== 16'(m_count)) begin errors++; $display("FAIL rand fetch_count: got %0d want %0d", fetch_count, m_count); end
`endif
      halted_cycles = m_halted ? halted_cycles + 1 : 0;
      if (halted_cycles > 4) begin halted_cycles = 0; do_reset(); end
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) imem[i] = 8'($urandom_range(0, 254));
    test_reset();
    test_sequential();
    test_stall();
    test_branch();
    test_wrap();
    test_halt();
    test_reset_in_halted();
    test_halt_branch();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
